// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a small {pc, inst} FIFO to decode.
// Optional FETCH_BYPASS_EN: forward the returning word straight to decode when the FIFO is empty.
module fetch_queue #(
    parameter int              WORD     = 32,
    parameter int              ADDR     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [ADDR-1:0] inst_addr_o,
    input  logic [WORD-1:0] inst_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_pc_i,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [ADDR-1:0] pc;
    logic            req_v;
    logic [ADDR-1:0] req_pc;

    logic [ADDR-1:0] pc_mem   [DEPTH];
    logic [WORD-1:0] inst_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [CW-1:0]   credit;
    logic            issue;
    logic            head_v;
    logic            byp_take;
    logic            push;
    logic            pop;

    // Slots already owned by stored entries plus the read still in flight.
    assign credit = count + CW'(req_v);
    assign issue  = !branch_i && (credit < CW'(DEPTH));
    assign head_v = (count != '0);

    assign inst_addr_o = pc;

`ifdef FETCH_BYPASS_EN
    logic byp;

    // Empty FIFO: the word arriving this cycle goes directly to decode.
    assign byp      = (count == '0) && req_v && !branch_i;
    assign byp_take = byp && !stall_i;
    assign v_o      = head_v || byp;
    assign inst_o   = byp ? inst_i : inst_mem[rd_ptr];
    assign pc_o     = byp ? req_pc : pc_mem[rd_ptr];
`else
    assign byp_take = 1'b0;
    assign v_o      = head_v;
    assign inst_o   = inst_mem[rd_ptr];
    assign pc_o     = pc_mem[rd_ptr];
`endif

    // A response consumed by bypass never occupies a slot.
    assign push = req_v && !branch_i && !byp_take;
    assign pop  = head_v && !stall_i && !branch_i;

    // Address generation and the single outstanding memory read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            req_v  <= 1'b0;
            req_pc <= '0;
        end else if (branch_i) begin
            pc     <= branch_pc_i;
            req_v  <= 1'b0;
        end else if (issue) begin
            pc     <= pc + ADDR'(1);
            req_v  <= 1'b1;
            req_pc <= pc;
        end else begin
            req_v  <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the idle outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= inst_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a mem[i] = 0x100 + i memory.
// Covers reset, streaming, stall fill, redirects, back-to-back redirects, mid-run reset.
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_pc_i;
    logic        v_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int          nvec;
    int          nerr;
    logic [31:0] exp_pc;
    logic [31:0] hold_pc;

    fetch_queue #(
        .WORD(32),
        .ADDR(32),
        .DEPTH(DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inst_addr_o(inst_addr_o),
        .inst_i(inst_i),
        .stall_i(stall_i),
        .branch_i(branch_i),
        .branch_pc_i(branch_pc_i),
        .v_o(v_o),
        .inst_o(inst_o),
        .pc_o(pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data for the address sampled at the edge.
    always @(posedge clk) inst_i <= 32'h100 + inst_addr_o;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge after a redirect/reset release; waits for the
    // first valid entry and checks it is the target.
    task automatic expect_first(input logic [31:0] target);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            chk("lat_v", {31'b0, v_o}, 32'd0);
        end
        @(negedge clk);
        chk("first_v", {31'b0, v_o}, 32'd1);
        chk("first_pc", pc_o, target);
        chk("first_inst", inst_o, 32'h100 + target);
        exp_pc = target + 1;
    endtask

    // One pop per cycle, in order, no bubbles.
    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("str_v", {31'b0, v_o}, 32'd1);
            chk("str_pc", pc_o, exp_pc);
            chk("str_inst", inst_o, 32'h100 + exp_pc);
            exp_pc = exp_pc + 1;
        end
    endtask

    initial begin
        nvec        = 0;
        nerr        = 0;
        exp_pc      = 0;
        hold_pc     = 0;
        inst_i      = 0;
        stall_i     = 0;
        branch_i    = 0;
        branch_pc_i = 0;
        reset       = 0;
        #1 reset = 1;
        #1;
        chk("rst_v", {31'b0, v_o}, 32'd0);
        chk("rst_addr", inst_addr_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);

        // 1: startup latency and steady stream
        repeat (2) @(negedge clk);
        reset = 0;
        expect_first(32'd0);
        stream(6);

        // 2: stall holds the head, fetch stops DEPTH past it
        hold_pc = exp_pc - 1;
        stall_i = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stall_v", {31'b0, v_o}, 32'd1);
            chk("stall_pc", pc_o, hold_pc);
            chk("stall_inst", inst_o, 32'h100 + hold_pc);
        end
        chk("stall_addr", inst_addr_o, hold_pc + DEPTH);
        stall_i = 0;
        stream(8);

        // 3: redirect with a full FIFO under stall
        hold_pc = exp_pc - 1;
        stall_i = 1;
        repeat (6) @(negedge clk);
        chk("full_addr", inst_addr_o, hold_pc + DEPTH);
        branch_i    = 1;
        branch_pc_i = 32'h20;
        @(negedge clk);
        chk("br_v", {31'b0, v_o}, 32'd0);
        chk("br_addr", inst_addr_o, 32'h20);
        branch_i = 0;
        stall_i  = 0;
        expect_first(32'h20);
        stream(4);

        // 4: branch and stall together while streaming
        stall_i     = 1;
        branch_i    = 1;
        branch_pc_i = 32'h30;
        @(negedge clk);
        chk("bs_v", {31'b0, v_o}, 32'd0);
        chk("bs_addr", inst_addr_o, 32'h30);
        stall_i  = 0;
        branch_i = 0;
        expect_first(32'h30);
        stream(4);

        // 5: back-to-back redirects, the first target never emerges
        branch_i    = 1;
        branch_pc_i = 32'h40;
        @(negedge clk);
        chk("bb1_v", {31'b0, v_o}, 32'd0);
        chk("bb1_addr", inst_addr_o, 32'h40);
        branch_pc_i = 32'h50;
        @(negedge clk);
        chk("bb2_v", {31'b0, v_o}, 32'd0);
        chk("bb2_addr", inst_addr_o, 32'h50);
        branch_i = 0;
        expect_first(32'h50);
        stream(4);

        // 6: asynchronous reset in the middle of a stream
        #2 reset = 1;
        #1;
        chk("mrst_v", {31'b0, v_o}, 32'd0);
        chk("mrst_addr", inst_addr_o, 32'd0);
        @(negedge clk);
        reset = 0;
        expect_first(32'd0);
        stream(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
